instr_cache_refill: RTL and testbench
=====================================

# instr_cache_refill

Line-fill engine for the direct-mapped instruction cache. On a fetch miss it captures the miss address and issues one block-aligned burst read on the memory read channel. It assembles the returned beats into a full cache block, then writes the block into the cache with a single-cycle `o_write_en` pulse that carries the line address and data. It sits between the fetch-stage miss logic and the memory/interconnect read port.

## Interface
Parameters:
- `BLOCK_WIDTH`, 512: cache block width in bits.
- `BUS_WIDTH`, 32: memory read data beat width; must divide `BLOCK_WIDTH`.
- `ADDR_WIDTH`, 64: address width.
- Derived `BEATS` = `BLOCK_WIDTH/BUS_WIDTH` (16).
- Derived `OFFS_W` = `$clog2(BLOCK_WIDTH/8)` (6).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `arstn`  in  1  asynchronous active-low reset.
- `i_miss`  in  1  fetch miss request; level, sampled in IDLE.
- `i_miss_addr`  in  ADDR_WIDTH  miss address.
- `o_busy`  out  1  refill in progress (state != IDLE).
- `o_ar_valid`  out  1  read address valid.
- `i_ar_ready`  in  1  read address accepted.
- `o_ar_addr`  out  ADDR_WIDTH  block-aligned burst address.
- `o_ar_len`  out  8  burst length minus one (`BEATS-1`), constant.
- `i_r_valid`  in  1  read data beat valid.
- `o_r_ready`  out  1  ready for a read data beat.
- `i_r_data`  in  BUS_WIDTH  read data beat.
- `i_r_err`  in  1  beat error response (used only with `REFILL_ERR_EN`).
- `o_write_en`  out  1  cache write strobe, one-cycle pulse.
- `o_line_addr`  out  ADDR_WIDTH  address presented to the cache with the write.
- `o_block`  out  BLOCK_WIDTH  assembled block.
- `o_access_fault`  out  1  refill fault pulse (tied 0 without `REFILL_ERR_EN`).

## Operation
- FSM states: IDLE, ADDR, DATA, WRITE.
- IDLE:
  - If `i_miss`, capture `i_miss_addr` with bits `[OFFS_W-1:0]` cleared into the line address register.
  - Clear the beat counter; go to ADDR.
- ADDR:
  - `o_ar_valid`=1 with `o_ar_addr` = line address. Address and valid are held stable until handshake.
  - On `i_ar_ready`, go to DATA.
- DATA:
  - `o_r_ready`=1. Each cycle with `i_r_valid`, the beat at counter k is written to `o_block[k*BUS_WIDTH +: BUS_WIDTH]` and the counter increments.
  - The beat that makes the count equal `BEATS` moves the FSM to WRITE.
  - The beat count alone terminates the burst; there is no last flag.
- WRITE:
  - `o_write_en`=1 for exactly one cycle; `o_line_addr` and `o_block` are stable.
  - Next state is IDLE.
- `o_line_addr` is the captured line address; its low `OFFS_W` bits are always zero.
- `o_block` retains its last contents between refills.
- Beat counter width is `$clog2(BEATS)+1`; it never wraps within a refill.
- `i_miss` held high after WRITE starts a new refill from IDLE. This is not back-to-back: IDLE always lasts ≥1 cycle.
- Changes to `i_miss_addr` after capture are ignored.
- Reset, any state:
  - Return to IDLE; the partial block is discarded.
  - `o_block`, `o_line_addr` and the beat counter go to 0.
  - All handshake outputs, `o_write_en` and `o_access_fault` go to 0.

## Timing
- Reset values: `o_busy`=0, `o_ar_valid`=0, `o_r_ready`=0, `o_write_en`=0, `o_access_fault`=0, `o_ar_addr`=0, `o_line_addr`=0, `o_block`=0.
- `o_ar_len` is constant.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- Cycle sequence:
  - Miss seen in cycle 0 → `o_ar_valid` high in cycle 1.
  - Address accepted in cycle n → `o_r_ready` high from cycle n+1.
  - Final beat accepted in cycle m → `o_write_en` in cycle m+1 → IDLE in m+2.
- Minimum refill latency, miss to `o_write_en`: `BEATS`+2 cycles (18), with zero-wait-state ready/valid.
- Stalls: `i_r_valid` gaps insert no bubbles beyond the stall itself. Ready/valid follow standard rules: transfer on the same-cycle high of both.
- `o_busy` is high from cycle 1 through the WRITE cycle inclusive.

## Configuration
- `REFILL_ERR_EN` defined:
  - `i_r_err` on any accepted beat sets a sticky error flag for the current refill.
  - All remaining beats are still accepted, to drain the burst.
  - In the WRITE cycle, `o_write_en` is suppressed and `o_access_fault` pulses for one cycle instead.
  - The flag clears on leaving WRITE and on reset.
- `REFILL_ERR_EN` not defined:
  - `i_r_err` is ignored and `o_access_fault` is constant 0.
  - Every completed burst is written.

## Test plan
- Miss at 0x0000_0000_0000_1234, zero-wait memory returning beat k = 0xA000_0000+k → `o_ar_addr`=0x...1200 and `o_ar_len`=15. `o_write_en` pulses exactly once, 18 cycles after the miss. `o_block[31:0]`=0xA000_0000 and `o_block[511:480]`=0xA000_000F.
- `i_ar_ready` held low 5 cycles → `o_ar_valid` and `o_ar_addr` stable all 5 cycles; `o_r_ready` stays 0 until the cycle after acceptance.
- `i_r_valid` toggled 1,0,0,1,… across 16 beats → beats land in order with no duplicates or skips; `o_write_en` comes one cycle after the 16th beat.
- `arstn` asserted after beat 7 → all outputs 0 immediately. A new miss at 0x4000 refills the full 16 beats; no stale data appears in `o_block`.
- `i_miss` held high continuously → `o_write_en` pulses separated by ≥1 IDLE cycle, and each refill issues exactly one address handshake.
- With `REFILL_ERR_EN`, `i_r_err`=1 on beat 3 → all 16 beats accepted, `o_write_en` stays 0, one-cycle `o_access_fault`. The next clean refill writes normally with no fault.

Source files
------------

// File: rtl/instr_cache_refill.sv
// Line-fill engine for the direct-mapped instruction cache: one block-aligned burst per miss,
// beats assembled into a block and written with a one-cycle strobe. Optional macro: REFILL_ERR_EN.
module instr_cache_refill #(
    parameter int BLOCK_WIDTH = 512,
    parameter int BUS_WIDTH   = 32,
    parameter int ADDR_WIDTH  = 64
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   i_miss,
    input  logic [ADDR_WIDTH-1:0]  i_miss_addr,
    output logic                   o_busy,
    output logic                   o_ar_valid,
    input  logic                   i_ar_ready,
    output logic [ADDR_WIDTH-1:0]  o_ar_addr,
    output logic [7:0]             o_ar_len,
    input  logic                   i_r_valid,
    output logic                   o_r_ready,
    input  logic [BUS_WIDTH-1:0]   i_r_data,
    input  logic                   i_r_err,
    output logic                   o_write_en,
    output logic [ADDR_WIDTH-1:0]  o_line_addr,
    output logic [BLOCK_WIDTH-1:0] o_block,
    output logic                   o_access_fault
);

    localparam int BEATS  = BLOCK_WIDTH / BUS_WIDTH;
    localparam int OFFS_W = $clog2(BLOCK_WIDTH / 8);
    localparam int CNT_W  = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        WRITE = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  line_addr_q, line_addr_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [BLOCK_WIDTH-1:0] block_q, block_d;
    logic [BEATS-1:0]       beat_sel;
    logic                   beat_fire;

    assign beat_fire = (state_q == DATA) && i_r_valid;

    // Each block slice loads only when its beat index is the one currently being accepted.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
            assign beat_sel[gi] = (beat_cnt_q == CNT_W'(gi));
            assign block_d[gi*BUS_WIDTH +: BUS_WIDTH] =
                (beat_fire && beat_sel[gi]) ? i_r_data : block_q[gi*BUS_WIDTH +: BUS_WIDTH];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        beat_cnt_d  = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (i_miss) begin
                    line_addr_d = {i_miss_addr[ADDR_WIDTH-1:OFFS_W], {OFFS_W{1'b0}}};
                    beat_cnt_d  = '0;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (i_ar_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (i_r_valid) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= IDLE;
            line_addr_q <= '0;
            beat_cnt_q  <= '0;
            block_q     <= '0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            beat_cnt_q  <= beat_cnt_d;
            block_q     <= block_d;
        end
    end

    assign o_busy      = (state_q != IDLE);
    assign o_ar_valid  = (state_q == ADDR);
    assign o_ar_addr   = line_addr_q;
    assign o_ar_len    = 8'(BEATS - 1);
    assign o_r_ready   = (state_q == DATA);
    assign o_line_addr = line_addr_q;
    assign o_block     = block_q;

`ifdef REFILL_ERR_EN
    logic err_q, err_d;

    // Sticky for the whole burst so the remaining beats still drain normally.
    always_comb begin
        err_d = err_q;
        if (state_q == WRITE) begin
            err_d = 1'b0;
        end else if (beat_fire && i_r_err) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_write_en     = (state_q == WRITE) && !err_q;
    assign o_access_fault = (state_q == WRITE) && err_q;
`else
    logic unused_r_err;
    assign unused_r_err   = i_r_err;
    assign o_write_en     = (state_q == WRITE);
    assign o_access_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_cache_refill.sv
// Randomized bench for instr_cache_refill: a memory responder drives the read channel, and a
// cycle-rule reference model plus a per-burst scoreboard check every output on every cycle.
module tb_instr_cache_refill;

    logic         clk = 1'b0;
    logic         arstn;
    logic         i_miss;
    logic [63:0]  i_miss_addr;
    logic         o_busy;
    logic         o_ar_valid;
    logic         i_ar_ready;
    logic [63:0]  o_ar_addr;
    logic [7:0]   o_ar_len;
    logic         i_r_valid;
    logic         o_r_ready;
    logic [31:0]  i_r_data;
    logic         i_r_err;
    logic         o_write_en;
    logic [63:0]  o_line_addr;
    logic [511:0] o_block;
    logic         o_access_fault;

    instr_cache_refill dut (
        .clk            (clk),
        .arstn          (arstn),
        .i_miss         (i_miss),
        .i_miss_addr    (i_miss_addr),
        .o_busy         (o_busy),
        .o_ar_valid     (o_ar_valid),
        .i_ar_ready     (i_ar_ready),
        .o_ar_addr      (o_ar_addr),
        .o_ar_len       (o_ar_len),
        .i_r_valid      (i_r_valid),
        .o_r_ready      (o_r_ready),
        .i_r_data       (i_r_data),
        .i_r_err        (i_r_err),
        .o_write_en     (o_write_en),
        .o_line_addr    (o_line_addr),
        .o_block        (o_block),
        .o_access_fault (o_access_fault)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Monitor-owned counters
    int ar_hs = 0, arv_cycles = 0, wr_cnt = 0, flt_cnt = 0, last_fire_cyc = 0, done_cyc = 0;
    // Responder-owned state
    int          r_beats = 0;
    logic [31:0] sent_words [16];
    // Test-owned configuration
    int          cfg_ar_wait = 0, cfg_rv_mode = 0, cfg_err_beat = -1;
    bit          cfg_fixed = 1'b0;
    logic [63:0] sb_line = '0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: ar_ready after cfg_ar_wait stalls, beats base+k with a valid pattern.
    initial begin
        int          wait_cnt;
        int          pc;
        logic [31:0] base;
        bit          v, ar_f, r_f;
        wait_cnt = 0; pc = 0; base = '0;
        i_ar_ready = 1'b0; i_r_valid = 1'b0; i_r_data = '0; i_r_err = 1'b0;
        forever begin
            @(negedge clk);
            ar_f = arstn && o_ar_valid && i_ar_ready;
            r_f  = arstn && o_r_ready && i_r_valid;
            @(posedge clk);
            #1;
            if (!arstn) begin
                r_beats = 0; wait_cnt = 0; pc = 0;
                i_ar_ready = 1'b0; i_r_valid = 1'b0; i_r_data = '0; i_r_err = 1'b0;
            end else begin
                if (ar_f) begin
                    r_beats = 0; pc = 0; wait_cnt = 0;
                    base = cfg_fixed ? 32'hA000_0000 : $urandom;
                end
                if (r_f && r_beats < 16) begin
                    sent_words[r_beats] = i_r_data;
                    r_beats++;
                end
                if (o_ar_valid) begin
                    if (wait_cnt >= cfg_ar_wait) i_ar_ready = 1'b1;
                    else begin
                        i_ar_ready = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    i_ar_ready = 1'b0;
                end
                if (o_r_ready && r_beats < 16) begin
                    case (cfg_rv_mode)
                        0:       v = 1'b1;
                        1:       v = 1'($urandom_range(0, 1));
                        default: v = (pc % 3 == 0);
                    endcase
                    pc++;
                    i_r_valid = v;
                    i_r_data  = v ? base + 32'(r_beats) : $urandom;
                    i_r_err   = v && (r_beats == cfg_err_beat);
                end else begin
                    i_r_valid = 1'b0; i_r_data = '0; i_r_err = 1'b0;
                end
            end
        end
    end

    // Reference model (phase 0 idle, 1 address, 2 data, 3 write) stepped from the inputs the DUT
    // will sample at the next edge, plus scoreboard checks on handshakes and write-backs.
    initial begin
        int           m_phase, m_cnt;
        logic [63:0]  m_addr;
        logic [511:0] m_block, exp_blk;
        bit           m_err;
        m_phase = 0; m_cnt = 0; m_addr = '0; m_block = '0; m_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!arstn) begin
                m_phase = 0; m_cnt = 0; m_addr = '0; m_block = '0; m_err = 1'b0;
                chk("rst_ar_addr", o_ar_addr, 64'h0);
            end
            chk("busy", o_busy, m_phase != 0);
            chk("ar_valid", o_ar_valid, m_phase == 1);
            if (m_phase == 1) chk("ar_addr", o_ar_addr, m_addr);
            chk("ar_len", o_ar_len, 8'd15);
            chk("r_ready", o_r_ready, m_phase == 2);
            chk("write_en", o_write_en, (m_phase == 3) && !m_err);
            chk("access_fault", o_access_fault, (m_phase == 3) && m_err);
            chk("line_addr", o_line_addr, m_addr);
            chk("block", o_block, m_block);
            if (arstn) begin
                if (o_ar_valid) arv_cycles++;
                if (o_ar_valid && i_ar_ready) begin
                    ar_hs++;
                    chk("sb_ar_addr", o_ar_addr, sb_line);
                end
                if (o_r_ready && i_r_valid) last_fire_cyc = cyc;
                if (o_write_en || o_access_fault) begin
                    done_cyc = cyc;
                    chk("sb_done_after_last_beat", cyc - last_fire_cyc, 1);
                end
                if (o_write_en) begin
                    wr_cnt++;
                    for (int k = 0; k < 16; k++) exp_blk[k*32 +: 32] = sent_words[k];
                    chk("sb_line_addr", o_line_addr, sb_line);
                    chk("sb_block", o_block, exp_blk);
                end
                if (o_access_fault) flt_cnt++;
                case (m_phase)
                    0: if (i_miss) begin
                        m_addr  = i_miss_addr & ~64'h3F;
                        m_cnt   = 0;
                        m_phase = 1;
                    end
                    1: if (i_ar_ready) m_phase = 2;
                    2: if (i_r_valid) begin
                        m_block[m_cnt*32 +: 32] = i_r_data;
`ifdef REFILL_ERR_EN
                        if (i_r_err) m_err = 1'b1;
`endif
                        m_cnt++;
                        if (m_cnt == 16) m_phase = 3;
                    end
                    default: begin
                        m_phase = 0;
                        m_err   = 1'b0;
                    end
                endcase
            end
        end
    end

    task automatic run_refill(input logic [63:0] addr, input int arw, input int rvm,
                              input int eb, input bit fixed, input bit scramble);
        int wr0, f0, hs0, arv0, miss_cyc, n;
        bit expect_fault;
        cfg_ar_wait = arw; cfg_rv_mode = rvm; cfg_err_beat = eb; cfg_fixed = fixed;
        sb_line = addr & ~64'h3F;
        wr0 = wr_cnt; f0 = flt_cnt; hs0 = ar_hs; arv0 = arv_cycles;
        @(posedge clk); #1;
        i_miss = 1'b1; i_miss_addr = addr;
        @(negedge clk);
        miss_cyc = cyc;
        @(posedge clk); #1;
        i_miss = 1'b0;
        if (scramble) i_miss_addr = {$urandom, $urandom};
        n = 0;
        while (n < 600 && (wr_cnt + flt_cnt) == (wr0 + f0)) begin
            @(negedge clk); #1;
            n++;
        end
        chk("refill_done", (wr_cnt + flt_cnt) != (wr0 + f0), 1'b1);
`ifdef REFILL_ERR_EN
        expect_fault = (eb >= 0 && eb < 16);
`else
        expect_fault = 1'b0;
`endif
        chk("write_count", wr_cnt - wr0, expect_fault ? 0 : 1);
        chk("fault_count", flt_cnt - f0, expect_fault ? 1 : 0);
        chk("ar_handshakes", ar_hs - hs0, 1);
        chk("ar_valid_cycles", arv_cycles - arv0, arw + 1);
        chk("beats_accepted", r_beats, 16);
        if (arw == 0 && rvm == 0) chk("miss_to_done_latency", done_cyc - miss_cyc, 18);
        repeat (2) begin
            @(negedge clk); #1;
        end
        chk("single_pulse", (wr_cnt + flt_cnt) - (wr0 + f0), 1);
        chk("idle_after_refill", o_busy, 1'b0);
        $display("refill addr=%h ar_wait=%0d rv_mode=%0d err_beat=%0d writes=%0d faults=%0d",
                 addr, arw, rvm, eb, wr_cnt - wr0, flt_cnt - f0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        int n, got, hs0, wr0;
        bit prev_wr;
        arstn = 1'b0; i_miss = 1'b0; i_miss_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", o_busy, 1'b0);
        chk("reset_write_en", o_write_en, 1'b0);
        chk("reset_block", o_block, 512'h0);
        chk("reset_line_addr", o_line_addr, 64'h0);
        @(posedge clk); #1;
        arstn = 1'b1;

        // Zero-wait burst with known data
        run_refill(64'h0000_0000_0000_1234, 0, 0, -1, 1'b1, 1'b0);
        chk("t1_line_addr", o_line_addr, 64'h1200);
        chk("t1_ar_len", o_ar_len, 8'd15);
        chk("t1_block_lo", o_block[31:0], 32'hA000_0000);
        chk("t1_block_hi", o_block[511:480], 32'hA000_000F);

        // Address stall and sparse data valid
        run_refill({$urandom, $urandom}, 5, 0, -1, 1'b0, 1'b1);
        run_refill({$urandom, $urandom}, 0, 2, -1, 1'b0, 1'b1);

        // Reset in the middle of a burst
        cfg_ar_wait = 0; cfg_rv_mode = 0; cfg_err_beat = -1; cfg_fixed = 1'b0;
        sb_line = 64'h2A40;
        wr0 = wr_cnt;
        @(posedge clk); #1;
        i_miss = 1'b1; i_miss_addr = 64'h2A40;
        @(posedge clk); #1;
        i_miss = 1'b0;
        n = 0;
        while (n < 100 && r_beats != 7) begin
            @(posedge clk); #2;
            n++;
        end
        chk("rst_mid_reached_beat7", r_beats, 7);
        arstn = 1'b0;
        #1;
        chk("rst_mid_busy", o_busy, 1'b0);
        chk("rst_mid_ar_valid", o_ar_valid, 1'b0);
        chk("rst_mid_r_ready", o_r_ready, 1'b0);
        chk("rst_mid_write_en", o_write_en, 1'b0);
        chk("rst_mid_fault", o_access_fault, 1'b0);
        chk("rst_mid_ar_addr", o_ar_addr, 64'h0);
        chk("rst_mid_line_addr", o_line_addr, 64'h0);
        chk("rst_mid_block", o_block, 512'h0);
        chk("rst_mid_no_write", wr_cnt - wr0, 0);
        repeat (3) @(posedge clk);
        #1;
        arstn = 1'b1;
        run_refill(64'h4000, 0, 0, -1, 1'b0, 1'b0);

        // Miss held high across three refills
        cfg_ar_wait = 0; cfg_rv_mode = 1; cfg_err_beat = -1; cfg_fixed = 1'b0;
        sb_line = 64'h0000_1234_5678_9A80;
        hs0 = ar_hs; wr0 = wr_cnt; got = 0; n = 0; prev_wr = 1'b0;
        @(posedge clk); #1;
        i_miss = 1'b1; i_miss_addr = 64'h0000_1234_5678_9ABC;
        while (n < 2000 && got < 3) begin
            @(negedge clk); #1;
            if (prev_wr) chk("held_miss_idle_gap", o_busy, 1'b0);
            prev_wr = o_write_en;
            if (o_write_en) got++;
            n++;
        end
        @(posedge clk); #1;
        i_miss = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("held_miss_writes", wr_cnt - wr0, 3);
        chk("held_miss_handshakes", ar_hs - hs0, 3);
        $display("held miss: writes=%0d handshakes=%0d", wr_cnt - wr0, ar_hs - hs0);

        // Error beat, then a clean refill
        run_refill({$urandom, $urandom}, 0, 0, 3, 1'b0, 1'b0);
        run_refill({$urandom, $urandom}, 1, 0, -1, 1'b0, 1'b0);

        for (int t = 0; t < 16; t++) begin
            run_refill({$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                       1'b0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
